sync_modn_loadable_updown_counter: RTL and testbench
====================================================

# sync_modn_loadable_updown_counter

Parametrised successor to the team's 4-bit loadable mod-12 up counter. It is a synchronous, loadable modulo-N counter with count enable, up/down direction, cascadable terminal-count output, a registered wrap pulse and a registered load-range error flag. It serves as the general-purpose divider and sequencer counter in the design. Cascading instances (tc of one stage driving en of the next) forms multi-digit counters such as BCD or time-of-day chains.

## Interface
- WIDTH, 4, width of data and q; must satisfy WIDTH ≥ 1.
- MODULUS, 12, count modulus N; legal range 2 ≤ N ≤ 2^WIDTH; count range is 0..N-1.

- clk  input  1  rising-edge clock; the block uses this single clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- load_en  input  1  parallel load request.
- data  input  WIDTH  load value.
- en  input  1  count enable; ignored while load_en=1.
- up  input  1  direction: 1 = increment, 0 = decrement.
- q  output  WIDTH  registered count.
- tc  output  1  combinational terminal count, for cascading.
- wrap  output  1  registered one-cycle pulse after a modulo wrap.
- load_err  output  1  registered one-cycle pulse after an out-of-range load.

## Operation
- Priority per edge: rst > load_en > en > hold.
- On rst: q=0, wrap=0, load_err=0.
- Load (load_en=1, rst=0):
  - If data < N: q ← data, load_err ← 0.
  - If data ≥ N: q ← 0, load_err ← 1.
  - In both cases wrap ← 0.
  - up and en are ignored.
- Count up (en=1, up=1):
  - If q == N-1: q ← 0 and wrap ← 1.
  - Otherwise q ← q+1 and wrap ← 0.
- Count down (en=1, up=0):
  - If q == 0: q ← N-1 and wrap ← 1.
  - Otherwise q ← q-1 and wrap ← 0.
- Hold (en=0, load_en=0): q unchanged; wrap ← 0 and load_err ← 0.
- tc = en & ~load_en & ((up & q==N-1) | (~up & q==0)).
  - tc is purely combinational from current inputs and q.
  - tc is asserted exactly in the cycle whose rising edge performs the wrap.
- Arithmetic:
  - All compares are unsigned on WIDTH bits.
  - Increment and decrement never rely on natural 2^WIDTH overflow, except when N == 2^WIDTH, where the results are identical.
  - The next-state value is always in 0..N-1.
- Direction may change on any cycle. The next step uses the up value sampled on that edge; there is no extra latency.
- A q value ≥ N is unreachable. If forced there (e.g. by X-injection or a glitch), the next count step loads 0 in either direction. This gives self-recovery in one enabled cycle.
- Illegal parameters (MODULUS < 2 or MODULUS > 2^WIDTH) must be rejected at elaboration (generate-time error).

## Timing
- Single clock domain. All state updates on the rising edge of clk.
- Load latency: 1 cycle (data is visible on q after the edge where load_en=1).
- Count latency: 1 cycle per enabled step.
- wrap and load_err are high for exactly the one cycle following the causing edge. Back-to-back causes produce back-to-back pulses.
- tc has no register stage. A downstream stage with en=tc advances on the same edge on which this stage wraps.
- Reset mid-count or mid-load: rst wins. On the next cycle q=0 and both flags are 0, regardless of load_en, en or data.
- Simultaneous load_en=1 with en=1 at a terminal value: the load is taken, wrap=0, and tc=0 in that cycle.
- After reset with en=0 and load_en=0, q stays 0 indefinitely.

## Test plan
- WIDTH=4, N=12:
  - Stimulus: rst for 2 cycles, then en=1, up=1 for 14 cycles.
  - Required response: q goes 0,1,…,11,0,1. tc is high while q=11. wrap is high the cycle q returns to 0.
- WIDTH=4, N=12, down count:
  - Stimulus: from q=2, en=1, up=0 for 4 cycles.
  - Required response: q goes 1,0,11,10. tc is high while q=0. wrap is high when q=11.
- Loads:
  - Stimulus: load data=7, then load data=13.
  - Required response: q=7 with load_err=0, then q=0 with load_err=1 for one cycle.
  - Stimulus: load_en=1 with en=1, up=1 while q=11.
  - Required response: the load value is taken and no wrap pulse occurs.
- Reset priority:
  - Stimulus: assert rst in the same cycle as load_en=1 and data=5, while q=9.
  - Required response: next q=0, wrap=0, load_err=0.
- Direction change and hold:
  - Stimulus: q=5, then up toggles each cycle with en=1.
  - Required response: q goes 6,5,6,5.
  - Stimulus: en=0 for 3 cycles.
  - Required response: q holds, tc=0.
- Cascade, N=10, WIDTH=4 (two instances):
  - Stimulus: enable the low digit continuously for 100 cycles from 00, with the high digit's en driven by the low digit's tc.
  - Required response: the pair counts 00..99 then 00. The high-digit wrap pulse occurs exactly once.
  - Also check a full-range instance with N=16: 15→0 wraps correctly.

Source files
------------

// File: rtl/sync_modn_loadable_updown_counter_if.sv
// Control/status bundle for the mod-N up/down counter.
// master drives load/count controls; slave is the counter.
interface sync_modn_loadable_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             load_en;
  logic [WIDTH-1:0] data;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output load_en,
    output data,
    output en,
    output up,
    input  q,
    input  tc,
    input  wrap,
    input  load_err
  );

  modport slave (
    input  load_en,
    input  data,
    input  en,
    input  up,
    output q,
    output tc,
    output wrap,
    output load_err
  );
endinterface

// File: rtl/sync_modn_loadable_updown_counter.sv
// Loadable modulo-N up/down counter with cascade tc,
// registered wrap pulse and registered load-range error.
module sync_modn_loadable_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input logic clk,
  input logic rst,
  sync_modn_loadable_updown_counter_if.slave bus
);

  if (WIDTH < 1 || MODULUS < 2 ||
      64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
    $error("illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             at_max, at_zero, over;

  always_comb begin
    at_max  = (q_q == MAX);
    at_zero = (q_q == '0);
    over    = (q_q > MAX);
  end

  always_comb begin
    q_d        = q_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (bus.load_en) begin
      if (bus.data > MAX) begin
        q_d        = '0;
        load_err_d = 1'b1;
      end else begin
        q_d = bus.data;
      end
    end else if (bus.en) begin
      // out-of-range q (never reached normally) recovers to 0
      if (bus.up) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else if (over) begin
          q_d = '0;
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX;
          wrap_d = 1'b1;
        end else if (over) begin
          q_d = '0;
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.q        = q_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;
  assign bus.tc       = bus.en & ~bus.load_en &
                        ((bus.up & at_max) | (~bus.up & at_zero));

endmodule

// File: tb/tb_sync_modn_loadable_updown_counter.sv
// Directed bench: mod-12 counter, BCD cascade pair,
// and a full-range mod-16 instance.
module tb_sync_modn_loadable_updown_counter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   hi_wraps;
  int   pair;

  always #5 clk = ~clk;

  sync_modn_loadable_updown_counter_if #(.WIDTH(4)) a ();
  sync_modn_loadable_updown_counter_if #(.WIDTH(4)) lo ();
  sync_modn_loadable_updown_counter_if #(.WIDTH(4)) hi ();
  sync_modn_loadable_updown_counter_if #(.WIDTH(4)) f ();

  sync_modn_loadable_updown_counter #(.WIDTH(4), .MODULUS(12)) u_a (
    .clk(clk), .rst(rst), .bus(a)
  );
  sync_modn_loadable_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rst(rst), .bus(lo)
  );
  sync_modn_loadable_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rst(rst), .bus(hi)
  );
  sync_modn_loadable_updown_counter #(.WIDTH(4), .MODULUS(16)) u_f (
    .clk(clk), .rst(rst), .bus(f)
  );

  assign hi.en      = lo.tc;
  assign hi.load_en = 1'b0;
  assign hi.data    = 4'd0;
  assign hi.up      = 1'b1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic ld, input logic [3:0] d,
                     input logic e, input logic u);
    a.load_en = ld;
    a.data    = d;
    a.en      = e;
    a.up      = u;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a.load_en = 0; a.data = 0; a.en = 0; a.up = 0;
    lo.load_en = 0; lo.data = 0; lo.en = 0; lo.up = 1;
    f.load_en = 0; f.data = 0; f.en = 0; f.up = 1;
    step();
    step();
    chk("rst_q", int'(a.q), 0);
    chk("rst_wrap", int'(a.wrap), 0);
    chk("rst_err", int'(a.load_err), 0);
    rst = 1'b0;

    // up count 14 cycles from 0
    drv(0, 0, 1, 1);
    for (int k = 0; k < 14; k++) begin
      chk("up_tc", int'(a.tc), (k % 12 == 11) ? 1 : 0);
      step();
      chk("up_q", int'(a.q), (k + 1) % 12);
      chk("up_wrap", int'(a.wrap), (k % 12 == 11) ? 1 : 0);
    end

    // down count from 2: 1,0,11,10
    drv(0, 0, 1, 0);
    chk("dn_tc0", int'(a.tc), 0);
    step(); chk("dn_q1", int'(a.q), 1);
    chk("dn_tc1", int'(a.tc), 0);
    step(); chk("dn_q0", int'(a.q), 0);
    chk("dn_tc2", int'(a.tc), 1);
    step(); chk("dn_q11", int'(a.q), 11);
    chk("dn_wrap", int'(a.wrap), 1);
    step(); chk("dn_q10", int'(a.q), 10);
    chk("dn_wrap_clr", int'(a.wrap), 0);

    // loads
    drv(1, 7, 0, 0);
    step(); chk("ld7_q", int'(a.q), 7);
    chk("ld7_err", int'(a.load_err), 0);
    drv(1, 13, 0, 0);
    step(); chk("ld13_q", int'(a.q), 0);
    chk("ld13_err", int'(a.load_err), 1);
    drv(1, 12, 1, 1);
    step(); chk("ld12_q", int'(a.q), 0);
    chk("ld12_err", int'(a.load_err), 1);
    drv(0, 0, 0, 1);
    step(); chk("hold_err_clr", int'(a.load_err), 0);
    drv(1, 11, 0, 0);
    step(); chk("ld11_q", int'(a.q), 11);
    chk("ld11_err", int'(a.load_err), 0);
    drv(1, 3, 1, 1);
    chk("ld_en_tc", int'(a.tc), 0);
    step(); chk("ld_en_q", int'(a.q), 3);
    chk("ld_en_wrap", int'(a.wrap), 0);

    // reset beats load
    drv(1, 9, 0, 0);
    step(); chk("ld9_q", int'(a.q), 9);
    rst = 1'b1;
    drv(1, 5, 1, 1);
    step(); rst = 1'b0;
    chk("rstp_q", int'(a.q), 0);
    chk("rstp_wrap", int'(a.wrap), 0);
    chk("rstp_err", int'(a.load_err), 0);

    // direction toggle from 5
    drv(1, 5, 0, 0);
    step();
    drv(0, 0, 1, 1); step(); chk("dir_q6a", int'(a.q), 6);
    drv(0, 0, 1, 0); step(); chk("dir_q5a", int'(a.q), 5);
    drv(0, 0, 1, 1); step(); chk("dir_q6b", int'(a.q), 6);
    drv(0, 0, 1, 0); step(); chk("dir_q5b", int'(a.q), 5);

    // hold at 0 with up=0: tc must stay low while en=0
    drv(1, 0, 0, 0);
    step();
    drv(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_tc", int'(a.tc), 0);
      step();
      chk("hold_q", int'(a.q), 0);
      chk("hold_wrap", int'(a.wrap), 0);
    end

    // BCD cascade 00..99 then 00
    hi_wraps = 0;
    lo.en = 1'b1;
    #1;
    for (int i = 1; i <= 100; i++) begin
      step();
      pair = int'(hi.q) * 10 + int'(lo.q);
      chk("casc_pair", pair, i % 100);
      if (hi.wrap) hi_wraps++;
    end
    lo.en = 1'b0;
    chk("casc_hi_wrap_once", hi_wraps, 1);

    // full-range N=16: 14 -> 15 -> 0 with wrap
    f.load_en = 1; f.data = 4'd14;
    step();
    chk("f_ld14", int'(f.q), 14);
    f.load_en = 0; f.en = 1; f.up = 1;
    #1;
    step(); chk("f_q15", int'(f.q), 15);
    chk("f_tc", int'(f.tc), 1);
    step(); chk("f_q0", int'(f.q), 0);
    chk("f_wrap", int'(f.wrap), 1);
    f.en = 0; f.up = 0;
    #1;
    step(); chk("f_hold", int'(f.q), 0);
    chk("f_wrap_clr", int'(f.wrap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
